// File: rtl/fifo_rd_drain_if.sv
// Read-port and output-stream bundle for fifo_rd_drain; master is the drain engine side.
// Parameters must match those of the fifo_rd_drain instance the bundle is connected to.
interface fifo_rd_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) ();
  logic                  rd_empty;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic                  chk_err;

  modport master (
    input  rd_empty, rd_data, out_ready,
    output rd_en, out_valid, out_data, word_cnt, chk_err
  );

  modport slave (
    output rd_empty, rd_data, out_ready,
    input  rd_en, out_valid, out_data, word_cnt, chk_err
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side FIFO drain: pops on credit, absorbs 1-cycle read latency in a 2-entry buffer, streams words out.
// Latency: pop to out_valid is 2 cycles; 1 word/cycle sustained. Backpressure: at most 2 words buffered, rd_en drops.
// Optional incrementing-pattern checker driving chk_err is compiled in with `define FIFO_RD_CHECK_EN.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           rd_clk,
  input  logic           rreset,
  fifo_rd_drain_if.master bus
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

  logic                  pop_now;
  logic                  tail_sel;
  logic                  rd_en_c;
  logic [2:0]            level;
  logic [DATA_WIDTH-1:0] head_dat;

  always_comb begin
    head_dat = head_q ? buf1_q : buf0_q;
    pop_now  = (occ_q != 2'd0) && bus.out_ready;
    // Words committed to the buffer after this cycle, counting the one still on rd_data.
    level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_now};
    rd_en_c  = !rreset && !bus.rd_empty && (level < 3'd2);
  end

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    head_d     = head_q;
    occ_d      = occ_q;
    inflight_d = rd_en_c;
    word_cnt_d = word_cnt_q;
    // Credit rule guarantees occ <= 1 whenever a word lands, so tail is head or its neighbour.
    tail_sel   = head_q ^ occ_q[0];
    if (inflight_q) begin
      if (tail_sel) begin
        buf1_d = bus.rd_data;
      end else begin
        buf0_d = bus.rd_data;
      end
    end
    if (pop_now) begin
      head_d     = ~head_q;
      word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop_now};
  end

  always_ff @(posedge rd_clk or posedge rreset) begin
    if (rreset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.rd_en     = rd_en_c;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = head_dat;
  assign bus.word_cnt  = word_cnt_q;

`ifdef FIFO_RD_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  chk_err_q, chk_err_d;

  always_comb begin
    exp_d     = exp_q;
    chk_err_d = chk_err_q;
    if (pop_now) begin
      if (head_dat != exp_q) begin
        chk_err_d = 1'b1;
      end
      exp_d = exp_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk or posedge rreset) begin
    if (rreset) begin
      exp_q     <= DATA_WIDTH'(1);
      chk_err_q <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO model feeding the DUT, scoreboard of pushed words.
module tb_fifo_rd_drain;
  localparam int DW = 32;
  localparam int CW = 5;
`ifdef FIFO_RD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic rd_clk = 1'b0;
  logic rreset = 1'b1;
  always #5 rd_clk = ~rd_clk;

  fifo_rd_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk (rd_clk),
    .rreset (rreset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];
  int            pop_cyc[$];
  int            cyc = 0;
  int            uflow = 0;
  bit            pop_fire = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  // FIFO model: pop decided at the clock edge, data and empty flag updated mid-cycle.
  always @(posedge rd_clk) begin
    pop_fire = (bus.rd_en === 1'b1);
    if (pop_fire) begin
      if (bus.rd_empty !== 1'b0) uflow++;
      pop_cyc.push_back(cyc);
    end
    cyc++;
  end

  always @(negedge rd_clk) begin
    if (pop_fire && fifo_q.size() > 0) bus.rd_data = fifo_q.pop_front();
    bus.rd_empty = (fifo_q.size() == 0);
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
  endtask

  task automatic do_reset();
    @(posedge rd_clk); #1;
    rreset = 1'b1;
    bus.out_ready = 1'b0;
    fifo_q.delete();
    sb_q.delete();
    repeat (2) @(posedge rd_clk);
    #1;
    rreset = 1'b0;
    exp_cnt = '0;
    pop_cyc.delete();
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    rreset = 1'b1;
    fifo_q.push_back(32'd99);
    for (int c = 0; c < 3; c++) begin
      @(negedge rd_clk);
      checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en cyc=%0d got=%b exp=0", c, bus.rd_en); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
      checks++; if (bus.word_cnt !== '0) begin failures++; $display("FAIL reset_word_cnt got=%0d exp=0", bus.word_cnt); end
      checks++; if (bus.chk_err !== 1'b0) begin failures++; $display("FAIL reset_chk_err got=%b exp=0", bus.chk_err); end
    end
  endtask

  task automatic test_single();
    int fv = -1;
    int nhs = 0;
    logic [DW-1:0] e;
    do_reset();
    bus.out_ready = 1'b1;
    push_word(32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge rd_clk);
      if (bus.out_valid === 1'b1 && fv < 0) fv = cyc;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        nhs++;
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL single_data got=%0d exp=%0d", bus.out_data, e); end
      end
    end
    checks++; if (nhs != 1) begin failures++; $display("FAIL single_handshakes got=%0d exp=1", nhs); end
    checks++; if (pop_cyc.size() != 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", pop_cyc.size()); end
    checks++; if (pop_cyc.size() == 0 || fv - pop_cyc[0] != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", (pop_cyc.size() == 0) ? -1 : fv - pop_cyc[0]); end
    checks++; if (bus.word_cnt !== CW'(1)) begin failures++; $display("FAIL single_word_cnt got=%0d exp=1", bus.word_cnt); end
  endtask

  task automatic test_stream(input int n, input string nm);
    int fv = -1;
    int lv = -1;
    int nv = 0;
    logic [DW-1:0] e;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= n; i++) push_word(DW'(i));
    for (int c = 0; c < n + 20; c++) begin
      @(negedge rd_clk);
      if (bus.out_valid === 1'b1) begin
        if (fv < 0) fv = cyc;
        lv = cyc;
        nv++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL %s_data got=%0d exp=%0d", nm, bus.out_data, e); end
        checks++; if (bus.word_cnt !== exp_cnt) begin failures++; $display("FAIL %s_word_cnt got=%0d exp=%0d", nm, bus.word_cnt, exp_cnt); end
        exp_cnt++;
      end
    end
    checks++; if (pop_cyc.size() != n || pop_cyc[$] - pop_cyc[0] != n - 1) begin failures++; $display("FAIL %s_pop_run got=%0d pops exp=%0d consecutive", nm, pop_cyc.size(), n); end
    checks++; if (nv != n || lv - fv != n - 1) begin failures++; $display("FAIL %s_valid_run got=%0d span=%0d exp=%0d", nm, nv, lv - fv + 1, n); end
    checks++; if (bus.word_cnt !== exp_cnt) begin failures++; $display("FAIL %s_final_cnt got=%0d exp=%0d", nm, bus.word_cnt, exp_cnt); end
    checks++; if (bus.chk_err !== 1'b0) begin failures++; $display("FAIL %s_chk_err got=%b exp=0", nm, bus.chk_err); end
  endtask

  task automatic test_backpressure();
    int fh = -1;
    int lh = -1;
    int nhs = 0;
    logic [DW-1:0] e;
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    repeat (8) @(negedge rd_clk);
    checks++; if (pop_cyc.size() != 2) begin failures++; $display("FAIL bp_pops got=%0d exp=2", pop_cyc.size()); end
    checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en_held got=%b exp=0", bus.rd_en); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1) begin failures++; $display("FAIL bp_head got=%b/%0d exp=1/1", bus.out_valid, bus.out_data); end
    @(posedge rd_clk); #1;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.rd_en !== 1'b1) begin failures++; $display("FAIL bp_rd_en_resume got=%b exp=1", bus.rd_en); end
    for (int c = 0; c < 12; c++) begin
      @(negedge rd_clk);
      if (bus.out_valid === 1'b1) begin
        if (fh < 0) fh = cyc;
        lh = cyc;
        nhs++;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL bp_data got=%0d exp=%0d", bus.out_data, e); end
      end
    end
    checks++; if (nhs != 4 || lh - fh != 3) begin failures++; $display("FAIL bp_gapless got=%0d words span=%0d exp=4", nhs, lh - fh + 1); end
  endtask

  task automatic test_checker();
    int h4 = -1;
    logic [DW-1:0] e;
    logic exp_err;
    do_reset();
    bus.out_ready = 1'b1;
    push_word(32'd1); push_word(32'd2); push_word(32'd4); push_word(32'd5);
    for (int c = 0; c < 14; c++) begin
      @(negedge rd_clk);
      exp_err = CHK && (h4 >= 0) && (cyc > h4);
      checks++; if (bus.chk_err !== exp_err) begin failures++; $display("FAIL chk_err cyc=%0d got=%b exp=%b", cyc, bus.chk_err, exp_err); end
      if (bus.out_valid === 1'b1) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL chk_data got=%0d exp=%0d", bus.out_data, e); end
        if (e == 32'd4) h4 = cyc;
      end
    end
    checks++; if (h4 < 0) begin failures++; $display("FAIL chk_word4_seen got=none exp=4"); end
  endtask

  task automatic test_midreset();
    int nhs = 0;
    logic [DW-1:0] e;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) push_word(DW'(i));
    for (int c = 0; c < 20 && nhs < 4; c++) begin
      @(negedge rd_clk);
      if (bus.out_valid === 1'b1) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        nhs++;
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL mid_pre_data got=%0d exp=%0d", bus.out_data, e); end
      end
    end
    @(posedge rd_clk); #1;
    rreset = 1'b1;
    #1;
    checks++; if (bus.rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_ctl got=%b%b exp=00", bus.rd_en, bus.out_valid); end
    checks++; if (bus.out_data !== '0 || bus.word_cnt !== '0) begin failures++; $display("FAIL mid_async_dat got=%0d/%0d exp=0/0", bus.out_data, bus.word_cnt); end
    fifo_q.delete();
    sb_q.delete();
    repeat (2) @(posedge rd_clk);
    #1;
    rreset = 1'b0;
    exp_cnt = '0;
    push_word(32'd7); push_word(32'd8);
    nhs = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge rd_clk);
      if (bus.out_valid === 1'b1) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        nhs++;
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL mid_post_data got=%0d exp=%0d", bus.out_data, e); end
        checks++; if (bus.word_cnt !== exp_cnt) begin failures++; $display("FAIL mid_post_cnt got=%0d exp=%0d", bus.word_cnt, exp_cnt); end
        exp_cnt++;
      end
    end
    checks++; if (nhs != 2 || bus.word_cnt !== CW'(2)) begin failures++; $display("FAIL mid_post_total got=%0d/%0d exp=2/2", nhs, bus.word_cnt); end
    checks++; if (bus.chk_err !== CHK) begin failures++; $display("FAIL mid_chk_err got=%b exp=%b", bus.chk_err, CHK); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_stream(16, "stream");
    test_backpressure();
    test_checker();
    test_stream(40, "wrap");
    test_midreset();
    checks++; if (uflow != 0) begin failures++; $display("FAIL underflow got=%0d exp=0", uflow); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
